// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data memory.
// Optional watchdog abort is compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [XLEN-1:0]     if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [XLEN-1:0]     dm_wdata,
    input  logic [XLEN/8-1:0]   dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [XLEN-1:0]     dm_rdata,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ready,
    output logic                bus_err
);
    localparam int BE_W = XLEN / 8;
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t              state, state_nxt;
    logic [SC_W-1:0]     starve_cnt, starve_nxt;
    logic [ADDR_W-1:0]   l_addr;
    logic                l_we;
    logic [XLEN-1:0]     l_wdata;
    logic [BE_W-1:0]     l_be;
    logic                busy, window, done, timeout, pick_if, pick_dm;

    assign busy = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
    logic [WC_W-1:0] wait_cnt;

    assign timeout = busy && !mem_ready && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   wait_cnt <= '0;
        else if (pick_if || pick_dm) wait_cnt <= '0;
        else if (busy && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Gating with rst keeps the combinational grants quiet while reset is held.
    assign window  = rst && (!busy || mem_ready);
    assign pick_if = window && if_req && (!dm_req || (starve_cnt >= SC_W'(STARVE_MAX)));
    assign pick_dm = window && dm_req && !pick_if;
    assign done    = busy && (mem_ready || timeout);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        if (pick_if)      state_nxt = BUSY_IF;
        else if (pick_dm) state_nxt = BUSY_DM;
        else if (done)    state_nxt = IDLE;

        if (pick_dm && if_req) begin
            if (starve_cnt < SC_W'(STARVE_MAX)) starve_nxt = starve_cnt + 1'b1;
        end else if (pick_if || !if_req) begin
            starve_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_addr  <= '0;
            l_we    <= 1'b0;
            l_wdata <= '0;
            l_be    <= '0;
        end else if (pick_if) begin
            l_addr  <= if_addr;
            l_we    <= 1'b0;
            l_wdata <= '0;
            l_be    <= '1;
        end else if (pick_dm) begin
            l_addr  <= dm_addr;
            l_we    <= dm_we;
            l_wdata <= dm_wdata;
            l_be    <= dm_be;
        end
    end

    assign if_gnt    = pick_if;
    assign dm_gnt    = pick_dm;
    assign if_rvalid = done && (state == BUSY_IF);
    assign dm_rvalid = done && (state == BUSY_DM);
    // An aborted transaction returns zero data to its owner.
    assign if_rdata  = (if_rvalid && !timeout) ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !timeout && !l_we) ? mem_rdata : '0;

    assign mem_ce    = busy;
    assign mem_we    = (state == BUSY_DM) && l_we;
    assign mem_addr  = busy ? l_addr  : '0;
    assign mem_wdata = busy ? l_wdata : '0;
    assign mem_be    = busy ? l_be    : '0;
    assign bus_err   = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, vector table,
// and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int XLEN = 32, ADDR_W = 32, STARVE_MAX = 4, TIMEOUT_CYC = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0, rst = 1'b0;
    logic              if_req = 0, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [XLEN-1:0]   if_rdata;
    logic              dm_req = 0, dm_we = 0, dm_gnt, dm_rvalid;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [XLEN-1:0]   dm_wdata = '0, dm_rdata;
    logic [3:0]        dm_be = '0;
    logic              mem_ce, mem_we, mem_ready = 0, bus_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata = '0;
    logic [3:0]        mem_be;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX),
                       .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns the memory, what was captured at grant,
    // how many DM wins in a row IF has sat through, and transaction age.
    int          owner;  // 0 none, 1 IF, 2 DM
    int          streak, age;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    int          p_win;
    logic        p_to, p_done;

    task automatic model_reset();
        owner = 0; streak = 0; age = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0;
    endtask

    task automatic predict();
        p_to   = TO_EN && owner != 0 && !mem_ready && age >= TIMEOUT_CYC;
        p_done = owner != 0 && (mem_ready || p_to);
        p_win  = 0;
        if (owner == 0 || mem_ready) begin
            if (if_req && (!dm_req || streak >= STARVE_MAX)) p_win = 1;
            else if (dm_req)                                 p_win = 2;
        end
    endtask

    task automatic update();
        if (p_win == 2 && if_req) begin
            if (streak < STARVE_MAX) streak++;
        end else if (p_win == 1 || !if_req) streak = 0;
        if (p_win == 1) begin
            owner = 1; age = 1; m_addr = if_addr; m_we = 0; m_wdata = 0; m_be = 4'hF;
        end else if (p_win == 2) begin
            owner = 2; age = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_be = dm_be;
        end else if (p_done) owner = 0;
        else if (owner != 0) age++;
    endtask

    task automatic compare_model();
        logic ifv, dmv;
        ifv = p_done && owner == 1;
        dmv = p_done && owner == 2;
        chk("if_gnt",    if_gnt,    p_win == 1);
        chk("dm_gnt",    dm_gnt,    p_win == 2);
        chk("if_rvalid", if_rvalid, ifv);
        chk("dm_rvalid", dm_rvalid, dmv);
        chk("if_rdata",  if_rdata,  (ifv && !p_to) ? mem_rdata : 32'h0);
        chk("dm_rdata",  dm_rdata,  (dmv && !p_to && !m_we) ? mem_rdata : 32'h0);
        chk("mem_ce",    mem_ce,    owner != 0);
        chk("mem_we",    mem_we,    owner == 2 && m_we);
        chk("mem_addr",  mem_addr,  owner != 0 ? m_addr  : 32'h0);
        chk("mem_wdata", mem_wdata, owner != 0 ? m_wdata : 32'h0);
        chk("mem_be",    mem_be,    owner != 0 ? m_be    : 4'h0);
        chk("bus_err",   bus_err,   p_to);
    endtask

    // One clock: model advances on the edge, inputs change on the falling edge.
    task automatic step();
        predict();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        bit ifr, dmr, rdy;
        bit ifg, dmg, ifv, dmv, ce;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit ifr, dmr, rdy, ifg, dmg, ifv, dmv, ce);
        vec_t v;
        v.ifr = ifr; v.dmr = dmr; v.rdy = rdy;
        v.ifg = ifg; v.dmg = dmg; v.ifv = ifv; v.dmv = dmv; v.ce = ce;
        tbl.push_back(v);
    endtask

    initial begin
        int k;
        logic seen;
        // Contention: four DM wins then IF, no idle gaps.
        add(1,1,1, 0,1,0,0,0);
        add(1,1,1, 0,1,0,1,1);
        add(1,1,1, 0,1,0,1,1);
        add(1,1,1, 0,1,0,1,1);
        add(1,1,1, 1,0,0,1,1);
        add(1,1,1, 0,1,1,0,1);
        add(1,1,1, 0,1,0,1,1);
        add(0,0,1, 0,0,0,1,1);
        add(0,0,0, 0,0,0,0,0);
        // Back-to-back: DM raised as the IF transaction completes.
        add(1,0,0, 1,0,0,0,0);
        add(0,0,0, 0,0,0,0,1);
        add(0,1,1, 0,1,1,0,1);
        add(0,0,0, 0,0,0,0,1);
        add(0,0,1, 0,0,0,1,1);
        add(0,0,0, 0,0,0,0,0);

        @(negedge clk);
        do_reset();
        #1;
        chk("reset_mem_ce", mem_ce, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_bus_err", bus_err, 0);

        // Reset in the middle of a DM transaction.
        @(negedge clk);
        dm_req = 1; dm_we = 0; dm_addr = 32'h40; mem_ready = 0;
        #1 chk("rst_mid_dm_gnt", dm_gnt, 1);
        @(negedge clk);
        dm_req = 0; if_req = 1; if_addr = 32'h200; mem_ready = 1;
        #1 chk("rst_mid_busy", mem_ce, 1);
        rst = 0;
        #1;
        chk("rst_mid_ce", mem_ce, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_if_gnt", if_gnt, 0);
        chk("rst_mid_dm_rvalid", dm_rvalid, 0);
        chk("rst_mid_be", mem_be, 0);
        @(negedge clk);
        rst = 1; mem_ready = 0;
        #1 chk("rst_release_if_gnt", if_gnt, 1);
        @(negedge clk);
        do_reset();

        // IF-only read with two-cycle latency.
        @(negedge clk);
        if_req = 1; if_addr = 32'h100; mem_ready = 0;
        #1 chk("if_only_gnt", if_gnt, 1);
        @(negedge clk);
        if_req = 0;
        #1;
        chk("if_only_addr", mem_addr, 32'h100);
        chk("if_only_be", mem_be, 4'hF);
        chk("if_only_we", mem_we, 0);
        chk("if_only_early_rvalid", if_rvalid, 0);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'h13;
        #1;
        chk("if_only_rvalid", if_rvalid, 1);
        chk("if_only_rdata", if_rdata, 32'h13);
        @(negedge clk);
        mem_ready = 0;
        #1 chk("if_only_idle_ce", mem_ce, 0);

        // DM write; attributes change after grant to prove they were captured.
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hCAFEF00D; dm_be = 4'h3;
        #1 chk("dm_wr_gnt", dm_gnt, 1);
        @(negedge clk);
        dm_req = 0; dm_addr = 32'h9999; dm_wdata = 32'h0; dm_be = 4'hF;
        #1;
        chk("dm_wr_we", mem_we, 1);
        chk("dm_wr_addr", mem_addr, 32'h2004);
        chk("dm_wr_wdata", mem_wdata, 32'hCAFEF00D);
        chk("dm_wr_be", mem_be, 4'h3);
        @(negedge clk);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("dm_wr_rvalid", dm_rvalid, 1);
        chk("dm_wr_rdata", dm_rdata, 0);
        @(negedge clk);
        mem_ready = 0; dm_we = 0;
        #1 chk("dm_wr_idle_we", mem_we, 0);

        // Long stall: abort after TIMEOUT_CYC cycles, or wait forever.
        do_reset();
        @(negedge clk);
        if_req = 1; if_addr = 32'h80; mem_ready = 0; mem_rdata = 32'h55;
        #1 chk("stall_gnt", if_gnt, 1);
        @(negedge clk);
        if_req = 0;
`ifdef ARB_TIMEOUT_EN
        k = 1;
        while (k <= 20) begin
            #1;
            if (bus_err) break;
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TIMEOUT_CYC);
        chk("timeout_rvalid", if_rvalid, 1);
        chk("timeout_rdata", if_rdata, 0);
        @(negedge clk);
        #1;
        chk("timeout_idle_ce", mem_ce, 0);
        chk("timeout_err_pulse", bus_err, 0);
`else
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            #1 if (bus_err || if_rvalid) seen = 1;
            @(negedge clk);
        end
        chk("stall_no_abort", seen, 0);
        chk("stall_still_busy", mem_ce, 1);
        mem_ready = 1;
        #1 chk("stall_rvalid", if_rvalid, 1);
        @(negedge clk);
`endif

        // Vector table.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            if_req = tbl[i].ifr; dm_req = tbl[i].dmr; mem_ready = tbl[i].rdy;
            if_addr = 32'h1000 + i; dm_addr = 32'h3000 + i; dm_we = 0;
            #1;
            chk($sformatf("tbl%0d_if_gnt", i),    if_gnt,    tbl[i].ifg);
            chk($sformatf("tbl%0d_dm_gnt", i),    dm_gnt,    tbl[i].dmg);
            chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].ifv);
            chk($sformatf("tbl%0d_dm_rvalid", i), dm_rvalid, tbl[i].dmv);
            chk($sformatf("tbl%0d_mem_ce", i),    mem_ce,    tbl[i].ce);
            step();
        end

        // Random traffic against the model; requests are held until granted.
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 2000; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_addr = $urandom; dm_we = $urandom_range(0, 1);
                dm_wdata = $urandom; dm_be = 4'($urandom);
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            #1;
            predict();
            compare_model();
            step();
            if (p_win == 1) if_req = 0;
            if (p_win == 2) dm_req = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
